uart_tx_sched: RTL

- Controller for the shared UART transmit FIFO.
- Round-robin arbiter between NUM_REQ byte producers for the FIFO write port.
- Drain sequencer moves bytes from the FIFO read port into the UART transmitter using a start/busy handshake.
- Sits between the register/DMA producers and the uart_fifo + transmitter pair.

---
 rtl/uart_tx_sched.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin FIFO write arbiter plus FIFO-to-UART drain FSM; UART_TX_SCHED_GAP_EN adds an inter-frame gap.
// Grant is same-cycle, fifo_rd +1 / tx_start +2 after FIFO non-empty; no grant while fifo_full, drain stalls on tx_busy.
module uart_tx_sched #(
    parameter int DATA_SIZE  = 8,
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_SIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr,
    output logic [DATA_SIZE-1:0]          fifo_wdata,
    input  logic                          fifo_full,
    output logic                          fifo_rd,
    input  logic [DATA_SIZE-1:0]          fifo_rdata,
    input  logic                          fifo_empty,
    output logic                          tx_start,
    output logic [DATA_SIZE-1:0]          tx_data,
    input  logic                          tx_busy,
    output logic                          sched_idle
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0) begin : g_bad_param
        $error("uart_tx_sched: NUM_REQ must be 2..8 and GAP_CYCLES >= 0");
    end

    logic [IW-1:0] rr_last;
    logic [IW-1:0] win;
    logic          found;

    always_comb begin
        win        = '0;
        found      = 1'b0;
        gnt        = '0;
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        // Lowest requester above rr_last beats any requester at or below it.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k] && (k <= int'(rr_last))) begin
                found = 1'b1;
                win   = IW'(k);
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k] && (k > int'(rr_last))) begin
                found = 1'b1;
                win   = IW'(k);
            end
        end
        if (found && !fifo_full && reset_n) begin
            fifo_wr = 1'b1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (int'(win) == k) begin
                    gnt[k]     = 1'b1;
                    fifo_wdata = req_data[k*DATA_SIZE +: DATA_SIZE];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= IW'(NUM_REQ - 1);
        end else if (fifo_wr) begin
            rr_last <= win;
        end
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
`ifdef UART_TX_SCHED_GAP_EN
        , S_GAP
`endif
    } state_t;

    state_t state;
    state_t state_nxt;

`ifdef UART_TX_SCHED_GAP_EN
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    logic [GW-1:0] gap_cnt;
    logic          gap_last;

    // A zero or one count both leave GAP after a single cycle.
    assign gap_last = (gap_cnt == '0) || (gap_cnt == GW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt <= '0;
        end else if (state == S_WAIT_DONE && !tx_busy) begin
            gap_cnt <= GW'(GAP_CYCLES);
        end else if (state == S_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            tx_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) begin
                tx_data <= fifo_rdata;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        fifo_rd    = 1'b0;
        tx_start   = 1'b0;
        sched_idle = 1'b0;
        case (state)
            S_IDLE: begin
                sched_idle = 1'b1;
                if (!fifo_empty) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                fifo_rd   = 1'b1;
                state_nxt = S_START;
            end
            S_START: begin
                tx_start  = 1'b1;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef UART_TX_SCHED_GAP_EN
                    state_nxt = S_GAP;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
`ifdef UART_TX_SCHED_GAP_EN
            S_GAP: begin
                if (gap_last) state_nxt = S_IDLE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
